// File: rtl/et_err_encoder_if.sv
// Signal bundle between an error-report source and the spill error encoder.
// err_valid is a one-cycle strobe with no backpressure: one report per cycle it is high.
interface et_err_encoder_if #(
  parameter int NCH = 232
);
  logic           in_live;
  logic           err_valid;
  logic [7:0]     err_chan;
  logic [NCH-1:0] err_bus;
  logic           got_err;
  logic [7:0]     err_count;
  logic           bad_chan;
  logic           busy;

  modport master (
    output in_live, err_valid, err_chan,
    input  err_bus, got_err, err_count, bad_chan, busy
  );

  modport slave (
    input  in_live, err_valid, err_chan,
    output err_bus, got_err, err_count, bad_chan, busy
  );
endinterface

// File: rtl/et_err_encoder.sv
// Collects per-channel error strobes during a spill (live window plus settle tail)
// and reports the accumulated error map, distinct-channel count and a one-cycle pulse.
module et_err_encoder #(
  parameter int NCH           = 232,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  et_err_encoder_if.slave     bus_if,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SETTLE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [NCH-1:0] acc_q, acc_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           bad_q, bad_d;
  logic [7:0]     settle_q, settle_d;
  logic [NCH-1:0] err_bus_q, err_bus_d;
  logic [7:0]     err_count_q, err_count_d;
  logic           got_err_q, got_err_d;

  logic           in_range;
  logic           hit;
  logic [NCH-1:0] onehot;
  logic           new_bit;
  logic [NCH-1:0] acc_upd;
  logic [7:0]     cnt_upd;
  logic           bad_upd;

  // Accumulator view including the strobe on the current edge.
  always_comb begin
    in_range = ({1'b0, bus_if.err_chan} < 9'(NCH));
    hit      = bus_if.err_valid && in_range;
    onehot   = '0;
    if (hit) begin
      onehot = {{(NCH-1){1'b0}}, 1'b1} << bus_if.err_chan;
    end
    new_bit  = |(onehot & ~acc_q);
    acc_upd  = acc_q | onehot;
    cnt_upd  = (new_bit && (cnt_q < 8'(NCH))) ? cnt_q + 8'd1 : cnt_q;
    bad_upd  = bad_q | (bus_if.err_valid && !in_range);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    settle_d    = settle_q;
    err_bus_d   = err_bus_q;
    err_count_d = err_count_q;
    got_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_if.in_live) begin
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        bad_d = bad_upd;
        if (!bus_if.in_live) begin
          state_d  = SETTLE;
          settle_d = 8'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        bad_d = bad_upd;
        // A new live window cuts the settle tail short.
        if (bus_if.in_live || (settle_q == 8'd0)) begin
          state_d     = IDLE;
          settle_d    = '0;
          err_bus_d   = acc_upd;
          err_count_d = cnt_upd;
          got_err_d   = 1'b1;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      settle_q    <= '0;
      err_bus_q   <= '0;
      err_count_q <= '0;
      got_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      settle_q    <= settle_d;
      err_bus_q   <= err_bus_d;
      err_count_q <= err_count_d;
      got_err_q   <= got_err_d;
    end
  end

  assign bus_if.err_bus   = err_bus_q;
  assign bus_if.err_count = err_count_q;
  assign bus_if.got_err   = got_err_q;
  assign bus_if.bad_chan  = bad_q;
  assign bus_if.busy      = (state_q != IDLE);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_et_err_encoder.sv
// Randomized and directed spills checked against a spill-level model of the error map.
module tb_et_err_encoder;
  localparam int NCH    = 232;
  localparam int SETTLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  et_err_encoder_if #(.NCH(NCH)) bus_if ();

  et_err_encoder #(.NCH(NCH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_if      (bus_if),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int             n_total = 0;
  int             n_bad   = 0;
  logic [NCH-1:0] exp_q[$];
  logic [7:0]     cnt_exp_q[$];
  logic [NCH-1:0] last_map;
  logic [7:0]     last_cnt;
  logic           last_bad;
  int             dir_err[int];
  logic [NCH-1:0] mon_map;
  logic [7:0]     mon_cnt;
  logic [NCH-1:0] k;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit lv, input bit ev, input int ch);
    bus_if.in_live   = lv;
    bus_if.err_valid = ev;
    bus_if.err_chan  = 8'(ch);
  endtask

  task automatic pick_err(input int c, input bit rnd, output bit ev, output int ch);
    if (dir_err.exists(c)) begin
      ev = 1'b1;
      ch = dir_err[c];
    end else if (rnd && ($urandom_range(0, 2) == 0)) begin
      ev = 1'b1;
      ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NCH, 255))
                                       : int'($urandom_range(0, NCH - 1));
    end else begin
      ev = 1'b0;
      ch = int'($urandom_range(0, 255));
    end
  endtask

  // Cycle 0 is the start edge; live cycles precede E0 at live_len; report at r.
  task automatic run_spill(input int live_len, input int abort_k, input bit rnd);
    logic [NCH-1:0] m;
    bit             bad;
    int             r;
    bit             ev;
    int             ch;
    m   = '0;
    bad = 1'b0;
    r   = (abort_k > 0) ? live_len + abort_k : live_len + SETTLE;
    for (int c = 0; c <= r; c++) begin
      @(negedge clk);
      chk("got_err_quiet", bus_if.got_err, 0);
      chk("busy_spill", bus_if.busy, (c > 0) ? 1 : 0);
      pick_err(c, rnd, ev, ch);
      drive((c < live_len) || ((abort_k > 0) && (c == r)), ev, ch);
      if (c > 0 && ev) begin
        if (ch < NCH) m[ch] = 1'b1;
        else bad = 1'b1;
      end
      if (c == r) begin
        exp_q.push_back(m);
        cnt_exp_q.push_back(8'($countones(m)));
      end
    end
    @(negedge clk);
    chk("got_err_pulse", bus_if.got_err, 1);
    chk("busy_after", bus_if.busy, 0);
    chk("bad_chan", bus_if.bad_chan, bad);
    last_map = m;
    last_cnt = 8'($countones(m));
    last_bad = bad;
    drive(0, 0, 0);
    dir_err.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_got_err", bus_if.got_err, 0);
      chk("idle_busy", bus_if.busy, 0);
      chk("idle_bus_hold", bus_if.err_bus, last_map);
      chk("idle_cnt_hold", bus_if.err_count, last_cnt);
      chk("idle_bad_hold", bus_if.bad_chan, last_bad);
      drive(0, $urandom_range(0, 1), int'($urandom_range(0, 255)));
    end
  endtask

  task automatic rst_mid(input int live_len, input int rst_at);
    for (int c = 0; c <= rst_at; c++) begin
      @(negedge clk);
      chk("rst_mid_quiet", bus_if.got_err, 0);
      if (c == rst_at) begin
        rst = 1'b1;
        drive(1, 1, 3);
      end else begin
        drive(c < live_len, 1, 3);
      end
    end
    @(negedge clk);
    chk("rst_got_err", bus_if.got_err, 0);
    chk("rst_bus", bus_if.err_bus, 0);
    chk("rst_cnt", bus_if.err_count, 0);
    chk("rst_bad", bus_if.bad_chan, 0);
    chk("rst_busy", bus_if.busy, 0);
    rst = 1'b0;
    drive(0, 0, 0);
    last_map = '0;
    last_cnt = '0;
    last_bad = 1'b0;
  endtask

  // Scoreboard: every report must match the oldest predicted spill.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_if.got_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_got_err", bus_if.got_err, 0);
      end else begin
        mon_map = exp_q.pop_front();
        mon_cnt = cnt_exp_q.pop_front();
        chk("report_bus", bus_if.err_bus, mon_map);
        chk("report_cnt", bus_if.err_count, mon_cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1, 5);
    repeat (3) @(negedge clk);
    chk("reset_got_err", bus_if.got_err, 0);
    chk("reset_bus", bus_if.err_bus, 0);
    chk("reset_cnt", bus_if.err_count, 0);
    chk("reset_bad", bus_if.bad_chan, 0);
    chk("reset_busy", bus_if.busy, 0);
    rst = 1'b0;
    drive(0, 1, 5);
    last_map = '0;
    last_cnt = '0;
    last_bad = 1'b0;
    idle(3);

    dir_err[1] = 0; dir_err[2] = 5; dir_err[3] = 231; dir_err[4] = 5;
    run_spill(6, 0, 0);
    k = '0; k[0] = 1'b1; k[5] = 1'b1; k[231] = 1'b1;
    chk("d031_bus", bus_if.err_bus, k);
    chk("d031_cnt", bus_if.err_count, 3);
    idle(2);

    run_spill(3, 0, 0);
    chk("d032_bus", bus_if.err_bus, 0);
    chk("d032_cnt", bus_if.err_count, 0);
    chk("d032_bad", bus_if.bad_chan, 0);
    idle(1);

    dir_err[1] = 232; dir_err[2] = 255; dir_err[3] = 7;
    run_spill(5, 0, 0);
    k = '0; k[7] = 1'b1;
    chk("d033_bus", bus_if.err_bus, k);
    chk("d033_cnt", bus_if.err_count, 1);
    chk("d033_bad", bus_if.bad_chan, 1);
    idle(2);

    dir_err[4] = 100; dir_err[4 + SETTLE] = 101;
    run_spill(4, 0, 0);
    k = '0; k[100] = 1'b1; k[101] = 1'b1;
    chk("d034_bus", bus_if.err_bus, k);
    chk("d034_cnt", bus_if.err_count, 2);
    idle(1);

    dir_err[1] = 20;
    run_spill(3, 4, 0);
    k = '0; k[20] = 1'b1;
    chk("d035_bus", bus_if.err_bus, k);
    dir_err[1] = 21;
    run_spill(3, 0, 0);
    k = '0; k[21] = 1'b1;
    chk("d035_next_bus", bus_if.err_bus, k);
    chk("d035_next_cnt", bus_if.err_count, 1);
    idle(1);

    rst_mid(8, 4);
    idle(2);
    dir_err[2] = 9;
    run_spill(3, 0, 0);
    k = '0; k[9] = 1'b1;
    chk("d036_bus", bus_if.err_bus, k);
    chk("d036_cnt", bus_if.err_count, 1);
    rst_mid(3, 10);
    idle(2);

    for (int i = 0; i < 25; i++) begin
      run_spill(int'($urandom_range(1, 20)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, SETTLE)) : 0, 1'b1);
      idle(int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/et_err_encoder.md
ET_ERR_ENCODER -- requirements
Module: et_err_encoder

Interface
REQ-001 Parameter: NCH, 232, number of error channels (width of reported bus).
REQ-002 Parameter: SETTLE_CYCLES, 16, post-live settle window in clocks (legal range 1..255).
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_live  input  1  live window; high = collect errors for the current spill.
REQ-006 err_valid  input  1  per-cycle strobe: one channel error report on err_chan.
REQ-007 err_chan  input  8  channel index of the reported error (0..NCH-1 legal).
REQ-008 err_bus  output  NCH  registered error map, bit i = channel i saw an error this spill.
REQ-009 got_err  output  1  registered one-cycle pulse: err_bus valid for the spill just ended.
REQ-010 err_count  output  8  registered number of distinct channels set in err_bus.
REQ-011 bad_chan  output  1  sticky flag: err_chan >= NCH was received this spill.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States SHALL be IDLE, COLLECT, SETTLE; no other encodings reachable.
REQ-014 IDLE: in_live=1 sampled -> clear accumulator, running count and bad_chan; go COLLECT on that edge.
REQ-015 IDLE: err_valid SHALL be ignored; err_bus and err_count hold last reported values.
REQ-016 COLLECT/SETTLE: err_valid=1 with err_chan<NCH SHALL set accumulator bit err_chan on that edge.
REQ-017 Repeated report of an already-set channel SHALL not change accumulator or running count.
REQ-018 Running count SHALL increment by 1 only when a previously clear bit is set; max NCH, no wrap.
REQ-019 err_valid=1 with err_chan>=NCH SHALL set bad_chan and SHALL not alter accumulator or count.
REQ-020 COLLECT: first edge sampling in_live=0 (edge E0) -> SETTLE, settle counter loaded SETTLE_CYCLES-1; error on E0 is recorded.
REQ-021 SETTLE: counter decrements each edge; on edge where counter=0 (edge E0+SETTLE_CYCLES) go IDLE and report.
REQ-022 Report edge SHALL load err_bus and err_count with accumulator/count including any error strobed on that same edge, and set got_err=1.
REQ-023 got_err SHALL be high for exactly one cycle per spill; low at all other times.
REQ-024 in_live=1 sampled during SETTLE -> report immediately on that edge (as REQ-022), go IDLE; next edge with in_live=1 starts a new spill.
REQ-025 in_live toggling back to 1 while in COLLECT (no low sample) SHALL be treated as one continuous spill.
REQ-026 A spill with zero errors SHALL still report: err_bus=0, err_count=0, got_err pulse.
REQ-027 bad_chan SHALL remain readable after report until cleared by next spill start or rst.

Reset
REQ-028 rst=1 on an edge SHALL force IDLE, accumulator=0, err_bus=0, err_count=0, got_err=0, bad_chan=0, settle counter=0; busy=0.
REQ-029 rst asserted mid-COLLECT or mid-SETTLE SHALL abort the spill with no got_err pulse.
REQ-030 rst has priority over every other input on the same edge.

Verification
REQ-031 Spill with errors on ch 0, 5, 231, ch 5 repeated; in_live falls -> after 16 edges got_err=1 one cycle, err_bus bits {0,5,231} set, err_count=3.
REQ-032 Spill with no err_valid -> got_err pulse, err_bus=0, err_count=0, bad_chan=0.
REQ-033 err_chan=232 and 255 in spill plus ch 7 -> err_bus only bit 7, err_count=1, bad_chan=1.
REQ-034 Error on ch 100 on E0 and ch 101 on report edge -> both bits set in reported err_bus, err_count=2.
REQ-035 in_live re-rises 4 cycles into SETTLE -> got_err on that edge with prior map; following spill starts with cleared accumulator.
REQ-036 rst pulsed mid-COLLECT after errors on ch 3 -> no got_err, all outputs 0, IDLE; next spill reports only its own errors.
